// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between an operand issuer (master) and seq_alu (slave).
interface seq_alu_if #(parameter int W = 8) ();
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [3:0]     s;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;
  logic           carry;
  logic           zero;
  logic           dz;

  modport master (
    output in_valid, a, b, s, out_ready,
    input  in_ready, out_valid, y, carry, zero, dz
  );

  modport slave (
    input  in_valid, a, b, s, out_ready,
    output in_ready, out_valid, y, carry, zero, dz
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked W-bit ALU: single-edge arithmetic/logic/shift ops and a W-step restoring
// divider returning {remainder, quotient}; results held in DONE until consumed.
module seq_alu #(
  parameter int W = 8
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0]   W_ZERO   = {W{1'b0}};
  localparam logic [W-1:0]   W_ONES   = {W{1'b1}};
  localparam logic [W-1:0]   W_ONE    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] Y_ZERO   = {(2*W){1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_INIT = CW'(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r, state_nx_s;
  logic [2*W-1:0] y_r;
  logic           carry_r, zero_r, dz_r;
  logic [W-1:0]   rem_r, quo_r, dvs_r;
  logic [CW-1:0]  cnt_r;

  logic           accept_s, div_start_s, div_last_s;
  logic [W:0]     sum_s;
  logic [2*W-1:0] alu_y_s;
  logic           alu_carry_s, alu_dz_s;
  logic [W:0]     rem_shift_s;
  logic           q_bit_s;
  logic [W-1:0]   rem_next_s, quo_next_s;

  assign accept_s    = bus.in_valid && (state_r == IDLE);
  assign div_start_s = accept_s && (bus.s == 4'd5) && (bus.b != W_ZERO);
  assign div_last_s  = (state_r == DIV) && (cnt_r == CNT_ONE);

  // The shifted partial remainder may reach W+1 bits; the W-bit difference is exact whenever it is kept.
  assign rem_shift_s = {rem_r, quo_r[W-1]};
  assign q_bit_s     = rem_shift_s[W] || (rem_shift_s[W-1:0] >= dvs_r);
  assign rem_next_s  = q_bit_s ? (rem_shift_s[W-1:0] - dvs_r) : rem_shift_s[W-1:0];
  assign quo_next_s  = {quo_r[W-2:0], q_bit_s};

  assign sum_s = {1'b0, bus.a} + {1'b0, bus.b};

  // Single-edge operation results, computed from the live operands at the accept edge
  always_comb begin
    alu_y_s     = Y_ZERO;
    alu_carry_s = 1'b0;
    alu_dz_s    = 1'b0;
    case (bus.s)
      4'd0: begin
        alu_y_s     = {{(W-1){1'b0}}, sum_s};
        alu_carry_s = sum_s[W];
      end
      4'd1: begin
        alu_y_s     = {W_ZERO, bus.a - bus.b};
        alu_carry_s = (bus.a < bus.b);
      end
      4'd2: begin
        alu_y_s     = {W_ZERO, bus.a + W_ONE};
        alu_carry_s = (bus.a == W_ONES);
      end
      4'd3: begin
        alu_y_s     = {W_ZERO, bus.a - W_ONE};
        alu_carry_s = (bus.a == W_ZERO);
      end
      4'd4:  alu_y_s = {W_ZERO, bus.a} * {W_ZERO, bus.b};
      4'd5: begin
        if (bus.b == W_ZERO) begin
          alu_y_s  = {bus.a, W_ONES};
          alu_dz_s = 1'b1;
        end else begin
          alu_y_s  = Y_ZERO;
          alu_dz_s = 1'b0;
        end
      end
      4'd6:  alu_y_s = {W_ZERO, bus.a & bus.b};
      4'd7:  alu_y_s = {W_ZERO, bus.a | bus.b};
      4'd8:  alu_y_s = {W_ZERO, bus.a ^ bus.b};
      4'd9:  alu_y_s = {W_ZERO, ~(bus.a & bus.b)};
      4'd10: alu_y_s = {W_ZERO, ~(bus.a | bus.b)};
      4'd11: alu_y_s = {W_ZERO, ~(bus.a ^ bus.b)};
      4'd12: begin
        alu_y_s     = {W_ZERO, bus.a[W-2:0], 1'b0};
        alu_carry_s = bus.a[W-1];
      end
      4'd13: begin
        alu_y_s     = {W_ZERO, 1'b0, bus.a[W-1:1]};
        alu_carry_s = bus.a[0];
      end
      4'd14: alu_y_s = {W_ZERO, bus.a[0], bus.a[W-1:1]};
      4'd15: alu_y_s = {W_ZERO, bus.a[W-2:0], bus.a[W-1]};
      default: begin
        alu_y_s     = Y_ZERO;
        alu_carry_s = 1'b0;
        alu_dz_s    = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = div_start_s ? DIV : DONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DIV: begin
        if (div_last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = DIV;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Result and divider datapath; result registers load only at accept or on the last divide step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r     <= Y_ZERO;
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
      dz_r    <= 1'b0;
      rem_r   <= W_ZERO;
      quo_r   <= W_ZERO;
      dvs_r   <= W_ZERO;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (div_start_s) begin
            rem_r <= W_ZERO;
            quo_r <= bus.a;
            dvs_r <= bus.b;
            cnt_r <= CNT_INIT;
          end else if (accept_s) begin
            y_r     <= alu_y_s;
            carry_r <= alu_carry_s;
            zero_r  <= (alu_y_s == Y_ZERO);
            dz_r    <= alu_dz_s;
          end
        end
        DIV: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (div_last_s) begin
            y_r     <= {rem_next_s, quo_next_s};
            carry_r <= 1'b0;
            zero_r  <= ({rem_next_s, quo_next_s} == Y_ZERO);
            dz_r    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.y         = y_r;
  assign bus.carry     = carry_r;
  assign bus.zero      = zero_r;
  assign bus.dz        = dz_r;
endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu (W=8 and W=16 instances).
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.W(8))  bus8 ();
  seq_alu_if #(.W(16)) bus16 ();

  seq_alu #(.W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  seq_alu #(.W(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  s;
    logic [15:0] y;
    logic        c;
    logic        z;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run8(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    check($sformatf("v%0d in_ready", idx), 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b1;
    bus8.a = v.a;
    bus8.b = v.b;
    bus8.s = v.s;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.a = ~v.a;
    bus8.b = ~v.b;
    bus8.s = ~v.s;
    lat = 1;
    @(negedge clk);
    while (!bus8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d y", idx), 32'(bus8.y), 32'(v.y));
    check($sformatf("v%0d carry", idx), 32'(bus8.carry), 32'(v.c));
    check($sformatf("v%0d zero", idx), 32'(bus8.zero), 32'(v.z));
    check($sformatf("v%0d dz", idx), 32'(bus8.dz), 32'(v.dz));
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    check($sformatf("v%0d out_valid after consume", idx), 32'(bus8.out_valid), 32'd0);
    check($sformatf("v%0d in_ready after consume", idx), 32'(bus8.in_ready), 32'd1);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                       input logic [31:0] ey, input logic ec, input logic edz, input int elat);
    int lat;
    @(negedge clk);
    bus16.in_valid = 1'b1;
    bus16.a = a;
    bus16.b = b;
    bus16.s = s;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    bus16.a = ~a;
    bus16.b = ~b;
    lat = 1;
    @(negedge clk);
    while (!bus16.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("w16 latency", 32'(lat), 32'(elat));
    check("w16 y", bus16.y, ey);
    check("w16 carry", 32'(bus16.carry), 32'(ec));
    check("w16 dz", 32'(bus16.dz), 32'(edz));
    check("w16 zero", 32'(bus16.zero), 32'(ey == 32'd0));
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
    check("w16 consumed", 32'(bus16.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    vecs[0]  = '{8'd200, 8'd100, 4'd0,  16'h012C, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{8'd0,   8'd0,   4'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{8'd5,   8'd7,   4'd1,  16'h00FE, 1'b1, 1'b0, 1'b0, 1};
    vecs[3]  = '{8'd0,   8'd0,   4'd3,  16'h00FF, 1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{8'hFF,  8'd0,   4'd2,  16'h0000, 1'b1, 1'b1, 1'b0, 1};
    vecs[5]  = '{8'd255, 8'd255, 4'd4,  16'hFE01, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{8'h81,  8'd0,   4'd12, 16'h0002, 1'b1, 1'b0, 1'b0, 1};
    vecs[7]  = '{8'h01,  8'd0,   4'd14, 16'h0080, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{8'd200, 8'd7,   4'd5,  16'h041C, 1'b0, 1'b0, 1'b0, 9};
    vecs[9]  = '{8'd9,   8'd0,   4'd5,  16'h09FF, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{8'hF0,  8'h3C,  4'd6,  16'h0030, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{8'hF0,  8'h0C,  4'd7,  16'h00FC, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{8'hFF,  8'h0F,  4'd8,  16'h00F0, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{8'hF0,  8'hFF,  4'd9,  16'h000F, 1'b0, 1'b0, 1'b0, 1};
    vecs[14] = '{8'hF0,  8'h0F,  4'd10, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[15] = '{8'hAA,  8'hAA,  4'd11, 16'h00FF, 1'b0, 1'b0, 1'b0, 1};
    vecs[16] = '{8'h81,  8'd0,   4'd13, 16'h0040, 1'b1, 1'b0, 1'b0, 1};
    vecs[17] = '{8'h80,  8'd0,   4'd15, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
    vecs[18] = '{8'd7,   8'd200, 4'd5,  16'h0700, 1'b0, 1'b0, 1'b0, 9};
    vecs[19] = '{8'd0,   8'd5,   4'd5,  16'h0000, 1'b0, 1'b1, 1'b0, 9};
    vecs[20] = '{8'd255, 8'd1,   4'd5,  16'h00FF, 1'b0, 1'b0, 1'b0, 9};
    vecs[21] = '{8'd7,   8'd5,   4'd1,  16'h0002, 1'b0, 1'b0, 1'b0, 1};

    rst_n = 1'b0;
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;
    bus8.a = 8'd0;  bus8.b = 8'd0;  bus8.s = 4'd0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus16.a = 16'd0; bus16.b = 16'd0; bus16.s = 4'd0;

    #3;
    check("reset out_valid", 32'(bus8.out_valid), 32'd0);
    check("reset y", 32'(bus8.y), 32'd0);
    check("reset carry", 32'(bus8.carry), 32'd0);
    check("reset zero", 32'(bus8.zero), 32'd0);
    check("reset dz", 32'(bus8.dz), 32'd0);
    check("reset in_ready", 32'(bus8.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      run8(vecs[i], i);
    end

    // Backpressure: result held while a competing op is offered
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.a = 8'd1; bus8.b = 8'd2; bus8.s = 4'd0;
    @(posedge clk);
    #1;
    bus8.a = 8'd10; bus8.b = 8'd3; bus8.s = 4'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d out_valid", k), 32'(bus8.out_valid), 32'd1);
      check($sformatf("bp%0d y", k), 32'(bus8.y), 32'd3);
      check($sformatf("bp%0d carry", k), 32'(bus8.carry), 32'd0);
      check($sformatf("bp%0d in_ready", k), 32'(bus8.in_ready), 32'd0);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    @(negedge clk);
    check("bp consumed out_valid", 32'(bus8.out_valid), 32'd0);
    check("bp consumed in_ready", 32'(bus8.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check("b2b out_valid", 32'(bus8.out_valid), 32'd1);
    check("b2b y", 32'(bus8.y), 32'd7);
    check("b2b carry", 32'(bus8.carry), 32'd0);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;

    // Reset four edges into a divide
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.a = 8'd200; bus8.b = 8'd7; bus8.s = 4'd5;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre-reset y", 32'(bus8.y), 32'd7);
    rst_n = 1'b0;
    #1;
    check("async reset y", 32'(bus8.y), 32'd0);
    check("async reset out_valid", 32'(bus8.out_valid), 32'd0);
    check("async reset in_ready", 32'(bus8.in_ready), 32'd1);
    check("async reset dz", 32'(bus8.dz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus8.out_valid) seen++;
    end
    check("abandoned divide out_valid", 32'(seen), 32'd0);
    run8(vecs[8], 100);

    // Wider instance
    run16(16'hFFFF, 16'h00FF, 4'd5, 32'h0000_0101, 1'b0, 1'b0, 17);
    run16(16'hFFFF, 16'h0001, 4'd0, 32'h0001_0000, 1'b1, 1'b0, 1);
    run16(16'hFFFF, 16'hFFFF, 4'd4, 32'hFFFE_0001, 1'b0, 1'b0, 1);
    run16(16'h1234, 16'h0000, 4'd5, 32'h1234_FFFF, 1'b0, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the 8-bit single-cycle ALU. It performs the same 16 arithmetic, logic, shift and rotate operations on W-bit operands. Divide runs as a multi-cycle restoring divider that returns both quotient and remainder and flags divide-by-zero. The block sits between an operand issuer and a result consumer, with valid/ready flow control on both sides.

## Interface
- `W`, default 8: operand width (≥2); result width is 2W.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: operands/opcode valid.
- `in_ready` output 1: block can accept a new operation.
- `a`, `b` input W: operands.
- `s` input 4: opcode.
- `out_valid` output 1: result valid; held until consumed.
- `out_ready` input 1: consumer accepts the result.
- `y` output 2W: result.
- `carry` output 1: carry/borrow/shifted-out bit.
- `zero` output 1: set when y == 0 (all 2W bits).
- `dz` output 1: divide-by-zero.

## Operation
- States: IDLE, DIV, DONE. `in_ready` = (state == IDLE), decoded combinationally from the state register.
- Acceptance: when `in_valid && in_ready` at a rising edge, `a`, `b` and `s` are captured.
- Opcode results (upper bits not listed are zero):
  - 0 add: y[W:0] = a+b; carry = y[W].
  - 1 sub: y[W-1:0] = a−b mod 2^W; carry = (a<b).
  - 2 inc: y[W-1:0] = a+1; carry = (a == all ones).
  - 3 dec: y[W-1:0] = a−1; carry = (a == 0).
  - 4 mul: y = a*b, full 2W bits; carry = 0.
  - 5 div: y = {remainder, quotient}.
  - 6 AND, 7 OR, 8 XOR, 9 NAND, 10 NOR, 11 XNOR: bitwise on W bits.
  - 12 shl: carry = a[W-1]. 13 shr: carry = a[0].
  - 14 rotate right. 15 rotate left.
- Flags: `carry` = 0 for opcodes 4 and 6–11, and 14–15. `dz` = 0 for every opcode except 5.
- Non-divide ops (and divide with b == 0): the result is computed and registered at the accept edge; state goes to DONE.
- Divide with b == 0: y = {a, all ones}, dz = 1, carry = 0; latency is the same as a non-divide op.
- Divide with b ≠ 0: state goes to DIV with a bit counter of W. Each DIV edge performs one restoring step: shift the remainder left, bring in the next dividend MSB, subtract b if the result is ≥ 0, and set the quotient bit. After W steps, y, the flags and state DONE are registered.
- DONE: `out_valid` = 1. `y`, `carry`, `zero` and `dz` are held stable. When `out_ready` = 1 at an edge, state goes to IDLE and `out_valid` drops.
- Zero flag: `zero` = (y == 0), evaluated on the final registered y for every op, including divide.
- Input behaviour outside IDLE: `in_valid`, `a`, `b` and `s` are ignored in DIV and DONE. Operand changes after acceptance do not affect the result.

## Timing
- Reset (`rst_n` low, asynchronous): state = IDLE, `out_valid` = 0, `y` = 0, `carry` = 0, `zero` = 0, `dz` = 0, and the divider registers are cleared. `in_ready` = 1 while in reset and after release.
- Reset mid-divide or in DONE: the operation is abandoned with no output. The first edge after `rst_n` rises may accept a new op.
- Latency (out_valid high in the cycle after):
  - non-divide / divide-by-zero: 1 edge after acceptance.
  - divide: W+1 edges after acceptance.
- Maximum throughput is one op per 2 cycles. A result is consumed at edge k, `in_ready` is 1 in cycle k+1, and a new op can be accepted at edge k+1.
- `out_ready` asserted while `out_valid` = 0 has no effect.
- Result registers update only on acceptance (single-cycle ops) or on the final DIV step.

## Test plan
- Reset then add, W=8: a=200, b=100, s=0 → one cycle later out_valid=1, y=0x012C, carry=1, zero=0. Also a=0, b=0 → y=0x0000, zero=1.
- Sub and dec with borrow: a=5, b=7, s=1 → y=0x00FE, carry=1. Then a=0, s=3 → y=0x00FF, carry=1.
- Mul, then shift/rotate: 255×255 → y=0xFE01, carry=0. shl of 0x81 → y=0x0002, carry=1. Rotate right of 0x01 → y=0x0080, carry=0.
- Divide: a=200, b=7, s=5 → out_valid rises exactly 9 edges after acceptance, y=0x041C, dz=0. Then a=9, b=0 → 1 edge, y=0x09FF, dz=1.
- Backpressure: hold out_ready=0 for 3 cycles after a result → y and flags stable, in_ready=0, and a concurrent in_valid is not accepted. Raise out_ready → back-to-back op accepted the next edge.
- Reset mid-divide: pulse rst_n low 4 edges into a divide → outputs 0 immediately (asynchronously), out_valid never rises for that op; the next op completes correctly. Repeat with W=16: 65535/255 → y=0x0000_0101.
